seq_restoring_divider: RTL and testbench

Sequential unsigned restoring divider that takes a 2N-bit dividend and an N-bit divisor and returns a 2N-bit quotient and N-bit remainder. It is the inverse companion of the 6x6 unsigned array multiplier: a multiplier `product` can be fed straight back as `dividend`, with either operand as `divisor`, for round-trip checks. The divider produces one quotient bit per clock and uses a start/busy/done handshake so it can sit beside the combinational datapath units in the lab ALU.

---
 rtl/seq_restoring_divider_if.sv | 24 ++
 rtl/seq_restoring_divider.sv | 119 +++++++++++
 tb/tb_seq_restoring_divider.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Operand/result bundle for the sequential restoring divider.
// Handshake: start is taken on a rising edge only when the divider is not busy; done pulses for one cycle.
interface seq_restoring_divider_if #(
    parameter int N = 6
) ();
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Results are architectural registers updated only when an operation completes.
module seq_restoring_divider #(
    parameter int N = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_restoring_divider_if.slave bus,
    output logic [1:0]            o_dbg_state
);
    localparam int W2 = 2 * N;
    localparam int CW = $clog2(W2);
    localparam logic [CW-1:0] LAST = CW'(W2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [N-1:0]    r_d;
    logic [W2-1:0]   r_q;
    logic [N-1:0]    r_r;
    logic [CW-1:0]   r_cnt;
    logic [W2-1:0]   r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_dbz;
    logic            w_accept;
    logic            w_zero;
    logic            w_last;
    logic            w_busy;
    logic            w_done;
    logic [N:0]      w_shift_r;
    logic [N:0]      w_t;
    logic [N-1:0]    w_r_next;
    logic [W2-1:0]   w_q_next;

    assign w_accept = bus.start && (r_state != S_BUSY);
    assign w_zero   = (bus.divisor == '0);
    assign w_last   = (r_cnt == LAST);

    // The partial remainder stays below D, so its top bit is always 0 between
    // steps and only N bits are stored; the shifted value needs N+1.
    assign w_shift_r = {r_r, r_q[W2-1]};
    assign w_t       = w_shift_r - {1'b0, r_d};
    assign w_r_next  = w_t[N] ? w_shift_r[N-1:0] : w_t[N-1:0];
    assign w_q_next  = {r_q[W2-2:0], ~w_t[N]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_done = (r_state == S_DONE);
                if (bus.start) begin
                    w_next_state = w_zero ? S_DONE : S_BUSY;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_d   <= bus.divisor;
            r_q   <= bus.dividend;
            r_r   <= '0;
            r_cnt <= '0;
            if (w_zero) begin
                r_quotient  <= '1;
                r_remainder <= '0;
                r_dbz       <= 1'b1;
            end
        end else if (r_state == S_BUSY) begin
            r_q   <= w_q_next;
            r_r   <= w_r_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_quotient  <= w_q_next;
                r_remainder <= w_r_next;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of seq_restoring_divider against plain integer division.
module tb_seq_restoring_divider;
    localparam int N  = 6;
    localparam int W2 = 2 * N;
    localparam int RW = 1 + W2 + N;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    seq_restoring_divider_if #(.N(N)) bus ();

    seq_restoring_divider #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] last_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {div_by_zero, quotient, remainder} from plain integer division.
    function automatic logic [RW-1:0] model(input logic [W2-1:0] dd, input logic [N-1:0] dv);
        logic [W2-1:0] q;
        logic [N-1:0]  r;
        if (dv == '0) return {1'b1, {W2{1'b1}}, {N{1'b0}}};
        q = dd / W2'(dv);
        r = N'(dd % W2'(dv));
        return {1'b0, q, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W2-1:0] dd, input logic [N-1:0] dv);
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.start    = 1'b1;
        exp_q.push_back(model(dd, dv));
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && edges < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            step();
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input int edges, input int busy_cnt);
        logic [RW-1:0] e;
        int            lat;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no expected result queued", tag);
            return;
        end
        e        = exp_q.pop_front();
        last_exp = e;
        lat      = e[RW-1] ? 0 : W2;
        chk({tag, "_latency"}, edges, lat);
        chk({tag, "_busy_cycles"}, busy_cnt, lat);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_busy_at_done"}, bus.busy, 0);
        chk({tag, "_quotient"}, bus.quotient, e[W2+N-1:N]);
        chk({tag, "_remainder"}, bus.remainder, e[N-1:0]);
        chk({tag, "_div_by_zero"}, bus.div_by_zero, e[RW-1]);
    endtask

    logic [W2-1:0] dd_list [6] = '{12'd2156, 12'd4095, 12'd1000, 12'd5, 12'd300, 12'd300};
    logic [N-1:0]  dv_list [6] = '{6'd44, 6'd63, 6'd7, 6'd12, 6'd0, 6'd10};

    initial begin
        int            edges;
        int            bcnt;
        int            pre_busy;
        int            done_seen;
        logic [W2-1:0] rdd;
        logic [N-1:0]  rdv;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        chk("rst_state", dbg_state, 0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        chk("no_self_start_busy", bus.busy, 0);
        chk("no_self_start_done", bus.done, 0);

        // Directed operand set, including divide-by-zero followed by a normal op.
        for (int i = 0; i < 6; i++) begin
            start_op(dd_list[i], dv_list[i]);
            wait_done(edges, bcnt);
            check_result($sformatf("dir%0d", i), edges, bcnt);
            step();
            chk($sformatf("dir%0d_done_pulse", i), bus.done, 0);
            chk($sformatf("dir%0d_hold_q", i), bus.quotient, last_exp[W2+N-1:N]);
        end

        // Start during BUSY must be ignored.
        start_op(12'd1000, 6'd7);
        pre_busy = 0;
        repeat (4) begin
            if (bus.busy === 1'b1) pre_busy++;
            step();
        end
        if (bus.busy === 1'b1) pre_busy++;
        bus.dividend = 12'd63;
        bus.divisor  = 6'd1;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(edges, bcnt);
        check_result("ignore_start", edges + 5, bcnt + pre_busy);
        done_seen = 0;
        repeat (16) begin
            step();
            if (bus.done === 1'b1) done_seen++;
        end
        chk("ignore_start_no_second_done", done_seen, 0);

        // Back-to-back: start held high through the first done.
        bus.dividend = 12'd4095;
        bus.divisor  = 6'd1;
        bus.start    = 1'b1;
        exp_q.push_back(model(12'd4095, 6'd1));
        step();
        bus.divisor = 6'd63;
        exp_q.push_back(model(12'd4095, 6'd63));
        wait_done(edges, bcnt);
        check_result("b2b_first", edges, bcnt);
        step();
        bus.start = 1'b0;
        chk("b2b_done_falls", bus.done, 0);
        chk("b2b_busy_rises", bus.busy, 1);
        chk("b2b_prev_held", bus.quotient, last_exp[W2+N-1:N]);
        wait_done(edges, bcnt);
        chk("b2b_gap", edges + 1, W2 + 1);
        check_result("b2b_second", edges, bcnt);
        step();

        // Reset mid-operation aborts without a done pulse.
        start_op(12'd2156, 6'd44);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_quotient", bus.quotient, 0);
        chk("midrst_remainder", bus.remainder, 0);
        chk("midrst_dbz", bus.div_by_zero, 0);
        chk("midrst_state", dbg_state, 0);
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (15) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        chk("midrst_no_activity", done_seen, 0);
        start_op(12'd2156, 6'd44);
        wait_done(edges, bcnt);
        check_result("after_rst", edges, bcnt);
        step();

        // Random operands, occasionally a zero divisor.
        for (int i = 0; i < 16; i++) begin
            rdd = W2'($urandom_range(0, 4095));
            rdv = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 63));
            start_op(rdd, rdv);
            wait_done(edges, bcnt);
            check_result($sformatf("rnd%0d", i), edges, bcnt);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
